dds_multi_channel: RTL and testbench

DDS_MULTI_CHANNEL -- requirements
Module: dds_multi_channel

---
 rtl/dds_pkg.sv | 15 +
 rtl/dds_channel.sv | 131 +++++++++++++
 rtl/dds_multi_channel.sv | 60 ++++++
 tb/tb_dds_multi_channel.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and default widths for the multi-channel DDS.
package dds_pkg;

  typedef enum logic [1:0] {
    SAW      = 2'd0,
    SQUARE   = 2'd1,
    TRIANGLE = 2'd2,
    PULSE    = 2'd3
  } mode_e;

  localparam int unsigned DEF_N_CH  = 2;
  localparam int unsigned DEF_ACC_W = 32;
  localparam int unsigned DEF_OUT_W = 8;

endpackage

// File: rtl/dds_channel.sv
// One DDS channel: accumulator, config shadow, waveform and scale stages.
// Optional amplitude stage enabled by DDS_AMPLITUDE_SCALE_EN.
module dds_channel
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_i,
  input  mode_e            mode_i,
  input  logic [ACC_W-1:0] adder_i,
  input  logic [ACC_W-1:0] duty_i,
  input  logic [OUT_W-1:0] amp_i,
  input  logic             imm_i,
  output logic             pend_o,
  output logic [OUT_W-1:0] sample_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] adder_q, adder_d;
  logic [ACC_W-1:0] duty_q, duty_d;
  mode_e            mode_q, mode_d;
  logic [OUT_W-1:0] amp_q, amp_d;

  logic [ACC_W-1:0] sh_adder_q;
  logic [ACC_W-1:0] sh_duty_q;
  mode_e            sh_mode_q;
  logic [OUT_W-1:0] sh_amp_q;
  logic             sh_imm_q;
  logic             pend_q, pend_d;

  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             apply;
  logic [OUT_W-1:0] wave_d, wave_q;

  // A stalled channel (adder 0) never wraps, so it takes updates at once.
  always_comb begin
    {carry, sum} = {1'b0, acc_q} + {1'b0, adder_q};
    apply = pend_q & (sh_imm_q | carry | (adder_q == '0));
    acc_d   = sum;
    adder_d = adder_q;
    duty_d  = duty_q;
    mode_d  = mode_q;
    amp_d   = amp_q;
    pend_d  = pend_q;
    if (apply) begin
      adder_d = sh_adder_q;
      duty_d  = sh_duty_q;
      mode_d  = sh_mode_q;
      amp_d   = sh_amp_q;
      pend_d  = 1'b0;
      if (sh_imm_q) acc_d = '0;
    end
    if (wr_i) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      adder_q <= '0;
      duty_q  <= '0;
      mode_q  <= SAW;
      amp_q   <= '1;
      pend_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      adder_q <= adder_d;
      duty_q  <= duty_d;
      mode_q  <= mode_d;
      amp_q   <= amp_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_adder_q <= '0;
      sh_duty_q  <= '0;
      sh_mode_q  <= SAW;
      sh_amp_q   <= '1;
      sh_imm_q   <= 1'b0;
    end else if (wr_i) begin
      sh_adder_q <= adder_i;
      sh_duty_q  <= duty_i;
      sh_mode_q  <= mode_i;
      sh_amp_q   <= amp_i;
      sh_imm_q   <= imm_i;
    end
  end

  always_comb begin
    wave_d = '0;
    unique case (mode_q)
      SAW:      wave_d = acc_q[ACC_W-1 -: OUT_W];
      SQUARE:   wave_d = {OUT_W{acc_q[ACC_W-1]}};
      TRIANGLE: wave_d = acc_q[ACC_W-2 -: OUT_W]
                         ^ {OUT_W{acc_q[ACC_W-1]}};
      PULSE:    wave_d = {OUT_W{acc_q < duty_q}};
      default:  wave_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wave_q <= '0;
    else          wave_q <= wave_d;
  end

`ifdef DDS_AMPLITUDE_SCALE_EN
  logic [2*OUT_W-1:0] prod;
  logic [OUT_W-1:0]   samp_q;

  assign prod = {{OUT_W{1'b0}}, wave_q} * {{OUT_W{1'b0}}, amp_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) samp_q <= '0;
    else          samp_q <= prod[2*OUT_W-1:OUT_W];
  end

  assign sample_o = samp_q;
`else
  logic unused_amp;
  assign unused_amp = ^amp_q;
  assign sample_o   = wave_q;
`endif

  assign pend_o = pend_q;

endmodule

// File: rtl/dds_multi_channel.sv
// Multi-channel DDS top: config handshake decode and channel array.
// Amplitude scaling stage selected by DDS_AMPLITUDE_SCALE_EN.
module dds_multi_channel
  import dds_pkg::*;
#(
  parameter  int unsigned N_CH  = DEF_N_CH,
  parameter  int unsigned ACC_W = DEF_ACC_W,
  parameter  int unsigned OUT_W = DEF_OUT_W,
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [1:0]           cfg_mode,
  input  logic [ACC_W-1:0]     cfg_adder,
  input  logic [ACC_W-1:0]     cfg_duty,
  input  logic [OUT_W-1:0]     cfg_amplitude,
  input  logic                 cfg_immediate,
  output logic [N_CH*OUT_W-1:0] sample_out
);

  localparam int unsigned N_SEL = 2 ** CH_W;

  logic [N_CH-1:0]  pend;
  logic [N_SEL-1:0] pend_ext;
  logic             accept;

  // Unpopulated channel slots never pend, so such writes are taken and dropped.
  for (genvar i = 0; i < N_SEL; i++) begin : g_sel
    if (i < N_CH) begin : g_on
      assign pend_ext[i] = pend[i];
    end else begin : g_off
      assign pend_ext[i] = 1'b0;
    end
  end

  assign cfg_ready = !pend_ext[cfg_ch];
  assign accept    = cfg_valid & cfg_ready;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    dds_channel #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_i     (accept && (cfg_ch == CH_W'(k))),
      .mode_i   (mode_e'(cfg_mode)),
      .adder_i  (cfg_adder),
      .duty_i   (cfg_duty),
      .amp_i    (cfg_amplitude),
      .imm_i    (cfg_immediate),
      .pend_o   (pend[k]),
      .sample_o (sample_out[k*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_dds_multi_channel.sv
// Directed self-checking bench for dds_multi_channel (N_CH=2, 32/8 bits).
// Expectations follow DDS_AMPLITUDE_SCALE_EN as seen at compile time.
module tb_dds_multi_channel;

  localparam int N_CH  = 2;
  localparam int ACC_W = 32;
  localparam int OUT_W = 8;
`ifdef DDS_AMPLITUDE_SCALE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                  clk;
  logic                  reset_n;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [0:0]            cfg_ch;
  logic [1:0]            cfg_mode;
  logic [ACC_W-1:0]      cfg_adder;
  logic [ACC_W-1:0]      cfg_duty;
  logic [OUT_W-1:0]      cfg_amplitude;
  logic                  cfg_immediate;
  logic [N_CH*OUT_W-1:0] sample_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int base0, base1, cnt;
  logic [7:0] w;

  dds_multi_channel #(
    .N_CH  (N_CH),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_ch        (cfg_ch),
    .cfg_mode      (cfg_mode),
    .cfg_adder     (cfg_adder),
    .cfg_duty      (cfg_duty),
    .cfg_amplitude (cfg_amplitude),
    .cfg_immediate (cfg_immediate),
    .sample_out    (sample_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] scale(input logic [7:0] wv,
                                       input logic [7:0] a);
`ifdef DDS_AMPLITUDE_SCALE_EN
    logic [15:0] p;
    p = {8'd0, wv} * {8'd0, a};
    return p[15:8];
`else
    logic unused_a;
    unused_a = ^a;
    return wv;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wr(input int ch, input logic [1:0] mode,
                    input logic [31:0] adder, input logic [31:0] duty,
                    input logic [7:0] amp, input logic imm);
    cfg_ch        = 1'(ch);
    cfg_mode      = mode;
    cfg_adder     = adder;
    cfg_duty      = duty;
    cfg_amplitude = amp;
    cfg_immediate = imm;
    cfg_valid     = 1'b1;
    #1;
    chk("wr_ready", {31'd0, cfg_ready}, 32'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    cfg_valid     = 1'b0;
    cfg_ch        = '0;
    cfg_mode      = 2'd0;
    cfg_adder     = '0;
    cfg_duty      = '0;
    cfg_amplitude = '0;
    cfg_immediate = 1'b0;
    #1;
    chk("rst_sample", {16'd0, sample_out}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_sample", {16'd0, sample_out}, 32'd0);

    // ch0 saw, 256-cycle period
    wr(0, 2'd0, 32'h0100_0000, 32'h0, 8'hFF, 1'b1);
    repeat (1 + LAT) tick();
    base0 = cyc;
    for (int j = 0; j < 260; j++) begin
      chk("saw_ch0", {24'd0, sample_out[7:0]}, {24'd0, scale(8'(j), 8'hFF)});
      chk("saw_ch1", {24'd0, sample_out[15:8]}, 32'd0);
      tick();
    end

    // ch1 square, ch0 keeps running
    wr(1, 2'd1, 32'h0800_0000, 32'h0, 8'hFF, 1'b1);
    repeat (1 + LAT) tick();
    base1 = cyc;
    for (int j = 0; j < 64; j++) begin
      w = ((j >> 4) & 1) != 0 ? 8'hFF : 8'h00;
      chk("sq_ch1", {24'd0, sample_out[15:8]}, {24'd0, scale(w, 8'hFF)});
      chk("sq_ch0_undisturbed", {24'd0, sample_out[7:0]},
          {24'd0, scale(8'(cyc - base0), 8'hFF)});
      tick();
    end

    // ch0 square at half amplitude
    wr(0, 2'd1, 32'h0800_0000, 32'h0, 8'h80, 1'b1);
    repeat (1 + LAT) tick();
    for (int j = 0; j < 32; j++) begin
      w = ((j >> 4) & 1) != 0 ? 8'hFF : 8'h00;
      chk("sq_amp80", {24'd0, sample_out[7:0]}, {24'd0, scale(w, 8'h80)});
      w = (((cyc - base1) >> 4) & 1) != 0 ? 8'hFF : 8'h00;
      chk("sq_ch1_run", {24'd0, sample_out[15:8]}, {24'd0, scale(w, 8'hFF)});
      tick();
    end

    // ch0 triangle
    wr(0, 2'd2, 32'h0800_0000, 32'h0, 8'hFF, 1'b1);
    repeat (1 + LAT) tick();
    for (int j = 0; j < 32; j++) begin
      w = 8'((j & 15) << 4);
      if ((j & 16) != 0) w = ~w;
      chk("tri", {24'd0, sample_out[7:0]}, {24'd0, scale(w, 8'hFF)});
      tick();
    end

    // ch0 pulse, duty quarter period
    wr(0, 2'd3, 32'h1000_0000, 32'h4000_0000, 8'hFF, 1'b1);
    repeat (1 + LAT) tick();
    for (int j = 0; j < 32; j++) begin
      w = (j % 16) < 4 ? 8'hFF : 8'h00;
      chk("pulse", {24'd0, sample_out[7:0]}, {24'd0, scale(w, 8'hFF)});
      tick();
    end

    // deferred update applied at wrap
    wr(0, 2'd0, 32'h1000_0000, 32'h0, 8'hFF, 1'b1);
    repeat (3) tick();
    wr(0, 2'd0, 32'h2000_0000, 32'h0, 8'hFF, 1'b0);
    cnt = 0;
    while (!cfg_ready && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("wrap_ready_low", 32'(cnt), 32'd13);
    repeat (LAT) tick();
    for (int j = 0; j < 16; j++) begin
      chk("wrap_new_period", {24'd0, sample_out[7:0]},
          {24'd0, scale(8'((j % 8) * 32), 8'hFF)});
      tick();
    end

    // reset discards a pending ch1 update
    wr(1, 2'd0, 32'h0100_0000, 32'h0, 8'hFF, 1'b1);
    repeat (10) tick();
    wr(1, 2'd0, 32'h0400_0000, 32'h0, 8'hFF, 1'b0);
    #1;
    chk("pend_ready_low", {31'd0, cfg_ready}, 32'd0);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("async_rst_sample", {16'd0, sample_out}, 32'd0);
    chk("async_rst_ready", {31'd0, cfg_ready}, 32'd1);
    tick();
    reset_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("post_rst_sample", {16'd0, sample_out}, 32'd0);
      chk("post_rst_ready", {31'd0, cfg_ready}, 32'd1);
    end

    // deferred write to a stalled channel lands next cycle
    wr(1, 2'd0, 32'h0100_0000, 32'h0, 8'hFF, 1'b0);
    #1;
    chk("stall_pend", {31'd0, cfg_ready}, 32'd0);
    tick();
    chk("stall_applied", {31'd0, cfg_ready}, 32'd1);
    repeat (LAT) tick();
    for (int j = 0; j < 16; j++) begin
      chk("stall_saw_ch1", {24'd0, sample_out[15:8]},
          {24'd0, scale(8'(j), 8'hFF)});
      chk("stall_ch0_idle", {24'd0, sample_out[7:0]}, 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
